// File: rtl/alu_result_wb.sv
// ALU result writeback stage: resolves branches and overflow exceptions as one-cycle
// pulses, and queues register-file writes in a FIFO drained through a valid/ready port.
module alu_result_wb #(
  parameter int DEPTH = 4,
  parameter int TID_W = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [TID_W-1:0]           in_tid,
  input  logic [4:0]                 in_rd,
  input  logic                       in_wen,
  input  logic [31:0]                in_data,
  input  logic                       in_eq,
  input  logic                       in_lt,
  input  logic                       in_ovf,
  input  logic [1:0]                 in_br,
  output logic                       br_valid,
  output logic [TID_W-1:0]           br_tid,
  output logic                       br_taken,
  output logic                       exc_valid,
  output logic [TID_W-1:0]           exc_tid,
  output logic                       wb_valid,
  input  logic                       wb_ready,
  output logic [TID_W-1:0]           wb_tid,
  output logic [4:0]                 wb_rd,
  output logic [31:0]                wb_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = TID_W + 5 + 32;

  // Handshakes: a transfer happens on a rising edge exactly when valid and ready are
  // both high; valid never depends on ready, and in_ready is purely occupancy based
  // (no bypass when full, even if the head is popping in the same cycle).

  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_br_valid;
  logic          r_br_taken;
  logic [TID_W-1:0] r_br_tid;
  logic          r_exc_valid;
  logic [TID_W-1:0] r_exc_tid;

  logic          w_accept;
  logic          w_is_exc;
  logic          w_is_br;
  logic          w_enq;
  logic          w_pop;
  logic          w_taken;
  logic [EW-1:0] w_head;

  assign in_ready = (r_count != CW'(DEPTH));
  assign wb_valid = (r_count != '0);
  assign w_accept = in_valid & in_ready;
  assign w_pop    = wb_valid & wb_ready;

  // Overflow wins over branch resolution; only plain writes to rd != 0 are queued.
  assign w_is_exc = w_accept & in_ovf;
  assign w_is_br  = w_accept & ~in_ovf & (in_br != 2'b00);
  assign w_enq    = w_accept & ~in_ovf & (in_br == 2'b00) & in_wen & (in_rd != 5'd0);

  always_comb begin
    w_taken = 1'b0;
    case (in_br)
      2'b01:   w_taken = in_eq;
      2'b10:   w_taken = ~in_eq;
      2'b11:   w_taken = in_lt;
      default: w_taken = 1'b0;
    endcase
  end

  assign w_head  = r_mem[r_rptr];
  assign wb_tid  = w_head[EW-1 -: TID_W];
  assign wb_rd   = w_head[36:32];
  assign wb_data = w_head[31:0];

  assign count     = r_count;
  assign br_valid  = r_br_valid;
  assign br_taken  = r_br_taken;
  assign br_tid    = r_br_tid;
  assign exc_valid = r_exc_valid;
  assign exc_tid   = r_exc_tid;

  always_ff @(posedge clk) begin
    if (!rst && w_enq) begin
      r_mem[r_wptr] <= {in_tid, in_rd, in_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_br_valid  <= 1'b0;
      r_br_taken  <= 1'b0;
      r_br_tid    <= '0;
      r_exc_valid <= 1'b0;
      r_exc_tid   <= '0;
    end else begin
      if (w_enq) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_enq, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_br_valid  <= w_is_br;
      r_br_taken  <= w_is_br & w_taken;
      if (w_is_br) r_br_tid <= in_tid;
      r_exc_valid <= w_is_exc;
      if (w_is_exc) r_exc_tid <= in_tid;
    end
  end

endmodule

// File: doc/alu_result_wb.md
ALU_RESULT_WB -- requirements
Module: alu_result_wb

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of result-queue entries (power of two, >= 2).
REQ-002 Parameter TID_W, default 2, SHALL set the thread-ID width.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  SHALL be the reset: synchronous, active-high.
REQ-005 in_valid  in  1  SHALL flag an ALU result offered this cycle.
REQ-006 in_ready  out  1  SHALL flag that a result can be accepted.
REQ-007 in_tid  in  TID_W  SHALL give the issuing thread.
REQ-008 in_rd  in  5  SHALL give the destination register.
REQ-009 in_wen  in  1  SHALL flag that the instruction writes rd.
REQ-010 in_data  in  32  SHALL carry the ALU result (alu_out).
REQ-011 in_eq, in_lt, in_ovf  in  1 each  SHALL carry the ALU eq, lt and overflow flags.
REQ-012 in_br  in  2  SHALL select the branch condition: 00 none, 01 beq, 10 bne, 11 blt.
REQ-013 br_valid  out  1, br_tid  out  TID_W, br_taken  out  1  SHALL report branch resolution.
REQ-014 exc_valid  out  1, exc_tid  out  TID_W  SHALL report an overflow exception.
REQ-015 wb_valid  out  1, wb_ready  in  1, wb_tid  out  TID_W, wb_rd  out  5, wb_data  out  32  SHALL form the register-file write port.
REQ-016 count  out  log2(DEPTH)+1  SHALL give the current queue occupancy.

Function
REQ-017 Accept SHALL occur exactly when in_valid and in_ready are both 1; in_ready SHALL equal (count != DEPTH), with no full-queue bypass even when a pop happens in the same cycle.
REQ-018 Accepted result with in_ovf=1 SHALL NOT be enqueued; exc_valid=1 with exc_tid=in_tid SHALL follow on the next cycle, as a one-cycle pulse.
REQ-019 Accepted result with in_br!=00 SHALL NOT be enqueued; br_valid=1 and br_tid=in_tid SHALL follow on the next cycle, as a one-cycle pulse.
REQ-020 br_taken SHALL be: in_eq for 01, ~in_eq for 10, in_lt for 11, registered with br_valid.
REQ-021 Overflow SHALL take priority: when in_ovf=1, br_valid SHALL stay 0 even if in_br!=00.
REQ-022 Accepted result with in_ovf=0, in_br=00, in_wen=1 and in_rd!=0 SHALL be enqueued as {tid, rd, data}.
REQ-023 Any other accepted result SHALL be dropped silently, with no output effect.
REQ-024 The queue SHALL be FIFO, with read/write pointers wrapping mod DEPTH.
REQ-025 wb_valid SHALL equal (count != 0); wb_tid, wb_rd and wb_data SHALL show the head entry combinationally.
REQ-026 Pop SHALL occur exactly when wb_valid and wb_ready are both 1.
REQ-027 While wb_valid=1 and wb_ready=0, the wb_* outputs SHALL hold stable.
REQ-028 An enqueue with no pop SHALL add 1 to count; a pop with no enqueue SHALL subtract 1; both in one cycle SHALL leave count unchanged (legal only when not full).
REQ-029 Latency SHALL be: an enqueued result is visible on wb_* in the cycle after accept when the queue was empty.
REQ-030 A result SHALL never be written back twice, and results SHALL never be reordered, across threads included.

Reset
REQ-031 While rst=1 at a clock edge: pointers and count SHALL clear to 0; br_valid, br_taken, exc_valid, br_tid and exc_tid SHALL clear to 0; queued entries SHALL be discarded.
REQ-032 During the cycle rst is sampled high, no accept or pop SHALL take effect.
REQ-033 After reset: in_ready=1, wb_valid=0, count=0.
REQ-034 Reset asserted mid-operation, including with a pending wb stall, SHALL discard all state with no partial writeback.

Verification
REQ-035 Enqueue/drain: push tid=1 rd=5 data=0x0000_00AA with wb_ready=1 -> next cycle wb_valid=1, wb_rd=5, wb_data=0xAA; following cycle count=0.
REQ-036 Full and stall: wb_ready=0, push 4 results -> count=4, in_ready=0; a 5th offer is not accepted; set wb_ready=1 -> results drain in push order; in_ready=1 after the first pop.
REQ-037 Branch resolution: in_br=11, in_lt=1, tid=2 -> next cycle br_valid=1, br_taken=1, br_tid=2, count unchanged. Repeat with in_br=10, in_eq=1 -> br_taken=0.
REQ-038 Overflow and drops: in_ovf=1, in_wen=1, rd=3, in_br=01 -> exc_valid=1 with exc_tid, br_valid=0, no enqueue. A separate push with rd=0 -> dropped, count=0.
REQ-039 Simultaneous push/pop: with count=2 and wb_ready=1, push one result -> count stays 2 and ordering is preserved.
REQ-040 Reset mid-stall: with count=3 and wb_ready=0, assert rst for one cycle -> count=0, wb_valid=0, in_ready=1; no stale entry appears afterward.
